// File: rtl/ipg_pkg.sv
// Shared IPG definitions: widths, FSM state encoding and request header codes.
package ipg_pkg;

  localparam int unsigned MSG_W   = 512;
  localparam int unsigned CHUNK_W = 64;
  localparam int unsigned MLEN_W  = 10;
  localparam int unsigned SLEN_W  = 7;

  // Header codes, shared with the receive-side message processor.
  localparam logic READ_REQ  = 1'b0;
  localparam logic WRITE_REQ = 1'b1;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/ipg_chunk_slice.sv
// Combinational chunk slicer: n = min(clamp64(slot_len), remaining), plus the
// top n bits of the window, MSB-aligned, with everything below them zeroed.
module ipg_chunk_slice
  import ipg_pkg::*;
(
  input  logic [CHUNK_W-1:0] top_bits,
  input  logic [SLEN_W-1:0]  slot_len,
  input  logic [MLEN_W-1:0]  remaining,
  output logic [SLEN_W-1:0]  n,
  output logic [CHUNK_W-1:0] chunk
);

  logic [MLEN_W-1:0] slot_clamped;
  logic [MLEN_W-1:0] n_wide;

  // Clamp the grant, take the min at MLEN_W, then mask the window to n bits.
  always_comb begin
    slot_clamped = (slot_len > SLEN_W'(CHUNK_W)) ? MLEN_W'(CHUNK_W)
                                                 : MLEN_W'(slot_len);
    n_wide       = (slot_clamped < remaining) ? slot_clamped : remaining;
    n            = SLEN_W'(n_wide);
    // A shift of CHUNK_W clears all ones, so n=64 yields a full mask.
    chunk        = top_bits & ~({CHUNK_W{1'b1}} >> n_wide);
  end

endmodule

// File: rtl/ipg_tx_serializer.sv
// Transmit serializer: accepts one message of up to MSG_W bits and releases it
// MSB-first into PHY-granted gap slots, one registered chunk per cycle.
module ipg_tx_serializer
  import ipg_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               msg_valid,
  output logic               msg_ready,
  input  logic [MSG_W-1:0]   msg_data,
  input  logic [MLEN_W-1:0]  msg_len,
  input  logic [SLEN_W-1:0]  slot_len,
  input  logic               abort,
  output logic [CHUNK_W-1:0] tx_ipg_data,
  output logic [SLEN_W-1:0]  tx_len,
  output logic               busy,
  output logic               msg_done
);

  state_e             state_q, state_d;
  logic [MSG_W-1:0]   shreg_q, shreg_d;
  logic [MLEN_W-1:0]  rem_q, rem_d;
  logic               msg_ready_q, msg_ready_d;
  logic [CHUNK_W-1:0] tx_data_q, tx_data_d;
  logic [SLEN_W-1:0]  tx_len_q, tx_len_d;
  logic               busy_q, busy_d;
  logic               msg_done_q, msg_done_d;

  logic [SLEN_W-1:0]  slice_n;
  logic [CHUNK_W-1:0] slice_chunk;

  ipg_chunk_slice u_slice (
    .top_bits  (shreg_q[MSG_W-1 -: CHUNK_W]),
    .slot_len  (slot_len),
    .remaining (rem_q),
    .n         (slice_n),
    .chunk     (slice_chunk)
  );

  // Next-state and registered-output computation for the IDLE/SEND FSM.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    rem_d      = rem_q;
    tx_data_d  = '0;
    tx_len_d   = '0;
    msg_done_d = 1'b0;

    case (state_q)
      STATE_IDLE: begin
        // A zero-length message is consumed without leaving IDLE.
        if (msg_valid && msg_ready_q && (msg_len != '0)) begin
          shreg_d = msg_data;
          rem_d   = msg_len;
          state_d = STATE_SEND;
        end
      end
      STATE_SEND: begin
        if (abort) begin
          rem_d   = '0;
          state_d = STATE_IDLE;
        end else begin
          tx_data_d = slice_chunk;
          tx_len_d  = slice_n;
          shreg_d   = shreg_q << slice_n;
          rem_d     = rem_q - MLEN_W'(slice_n);
          if (rem_d == '0) begin
            msg_done_d = 1'b1;
            state_d    = STATE_IDLE;
          end
        end
      end
      default: state_d = STATE_IDLE;
    endcase

    // Ready/busy are registered views of the state being entered.
    msg_ready_d = (state_d == STATE_IDLE);
    busy_d      = (state_d == STATE_SEND);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= STATE_IDLE;
      shreg_q     <= '0;
      rem_q       <= '0;
      msg_ready_q <= 1'b0;
      tx_data_q   <= '0;
      tx_len_q    <= '0;
      busy_q      <= 1'b0;
      msg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rem_q       <= rem_d;
      msg_ready_q <= msg_ready_d;
      tx_data_q   <= tx_data_d;
      tx_len_q    <= tx_len_d;
      busy_q      <= busy_d;
      msg_done_q  <= msg_done_d;
    end
  end

  assign msg_ready   = msg_ready_q;
  assign tx_ipg_data = tx_data_q;
  assign tx_len      = tx_len_q;
  assign busy        = busy_q;
  assign msg_done    = msg_done_q;

endmodule

// File: tb/tb_ipg_tx_serializer.sv
// Directed self-checking bench for ipg_tx_serializer.
module tb_ipg_tx_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         msg_valid;
  logic         msg_ready;
  logic [511:0] msg_data;
  logic [9:0]   msg_len;
  logic [6:0]   slot_len;
  logic         abort;
  logic [63:0]  tx_ipg_data;
  logic [6:0]   tx_len;
  logic         busy;
  logic         msg_done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ipg_tx_serializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .msg_data    (msg_data),
    .msg_len     (msg_len),
    .slot_len    (slot_len),
    .abort       (abort),
    .tx_ipg_data (tx_ipg_data),
    .tx_len      (tx_len),
    .busy        (busy),
    .msg_done    (msg_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; msg_valid = 1'b0; msg_data = '0; msg_len = '0;
    slot_len = 7'd64; abort = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({msg_ready, busy, msg_done} !== 3'b000 || tx_len !== 7'd0 || tx_ipg_data !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b busy=%b done=%b len=%0d data=%h, required all zero",
               msg_ready, busy, msg_done, tx_len, tx_ipg_data);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (msg_ready !== 1'b1 || tx_len !== 7'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b len=%0d busy=%b, required ready=1 len=0 busy=0",
               msg_ready, tx_len, busy);
    end
  endtask

  task automatic test_full_message();
    logic [63:0] w;
    w = 64'hA5A5_0000_FFFF_1234;
    msg_data = {8{w}}; msg_len = 10'd512; msg_valid = 1'b1; slot_len = 7'd64;
    tick();
    msg_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || msg_ready !== 1'b0 || tx_len !== 7'd0) begin
      n_fail++;
      $display("FAIL full_accept: busy=%b ready=%b len=%0d, required busy=1 ready=0 len=0",
               busy, msg_ready, tx_len);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (tx_ipg_data !== w || tx_len !== 7'd64 || msg_done !== (i == 7)) begin
        n_fail++;
        $display("FAIL full_chunk%0d: data=%h len=%0d done=%b, required data=%h len=64 done=%b",
                 i, tx_ipg_data, tx_len, msg_done, w, (i == 7));
      end
    end
    n_checks++;
    if (msg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready_back: ready=%b busy=%b, required ready=1 busy=0", msg_ready, busy);
    end
    tick();
    n_checks++;
    if (tx_len !== 7'd0 || msg_done !== 1'b0 || tx_ipg_data !== 64'd0) begin
      n_fail++;
      $display("FAIL full_after: len=%0d done=%b data=%h, required 0/0/0", tx_len, msg_done, tx_ipg_data);
    end
  endtask

  task automatic test_odd_slots();
    logic [6:0]  slots [4];
    logic [6:0]  exp_len [4];
    logic [63:0] exp_data [4];
    slots    = '{7'd7, 7'd0, 7'd20, 7'd63};
    exp_len  = '{7'd7, 7'd0, 7'd20, 7'd37};
    exp_data = '{64'hF000_0000_0000_0000, 64'h0, 64'h7878_7000_0000_0000, 64'h8787_8787_8000_0000};
    msg_data = {64'hF0F0_F0F0_F0F0_F0F0, 448'd0}; msg_len = 10'd64; msg_valid = 1'b1;
    slot_len = 7'd64;
    tick();
    msg_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slot_len = slots[i];
      tick();
      n_checks++;
      if (tx_ipg_data !== exp_data[i] || tx_len !== exp_len[i] || msg_done !== (i == 3)) begin
        n_fail++;
        $display("FAIL odd_slot%0d: data=%h len=%0d done=%b, required data=%h len=%0d done=%b",
                 i, tx_ipg_data, tx_len, msg_done, exp_data[i], exp_len[i], (i == 3));
      end
    end
    tick();
  endtask

  task automatic test_clamp_short();
    msg_data = {5'b10110, {507{1'b1}}}; msg_len = 10'd5; msg_valid = 1'b1; slot_len = 7'd100;
    tick();
    msg_valid = 1'b0;
    tick();
    n_checks++;
    if (tx_ipg_data !== 64'hB000_0000_0000_0000 || tx_len !== 7'd5 || msg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_short: data=%h len=%0d done=%b, required data=b000000000000000 len=5 done=1",
               tx_ipg_data, tx_len, msg_done);
    end
    tick();
  endtask

  task automatic test_abort();
    logic [63:0] w0, w1, nw;
    w0 = 64'h0123_4567_89AB_CDEF;
    w1 = 64'hFEDC_BA98_7654_3210;
    nw = 64'hCAFE_F00D_DEAD_BEEF;
    msg_data = {w0, w1, {6{64'h5555_5555_5555_5555}}}; msg_len = 10'd512;
    msg_valid = 1'b1; slot_len = 7'd64;
    tick();
    msg_valid = 1'b0;
    tick();
    n_checks++;
    if (tx_ipg_data !== w0 || tx_len !== 7'd64) begin
      n_fail++;
      $display("FAIL abort_chunk0: data=%h len=%0d, required data=%h len=64", tx_ipg_data, tx_len, w0);
    end
    tick();
    n_checks++;
    if (tx_ipg_data !== w1 || tx_len !== 7'd64) begin
      n_fail++;
      $display("FAIL abort_chunk1: data=%h len=%0d, required data=%h len=64", tx_ipg_data, tx_len, w1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (tx_len !== 7'd0 || tx_ipg_data !== 64'd0 || msg_done !== 1'b0 || msg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_cut: len=%0d data=%h done=%b ready=%b busy=%b, required 0/0/0/1/0",
               tx_len, tx_ipg_data, msg_done, msg_ready, busy);
    end
    msg_data = {nw, 448'd0}; msg_len = 10'd64; msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
    tick();
    n_checks++;
    if (tx_ipg_data !== nw || tx_len !== 7'd64 || msg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_next_msg: data=%h len=%0d done=%b, required data=%h len=64 done=1",
               tx_ipg_data, tx_len, msg_done, nw);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] m1, m2;
    int unsigned done_cnt;
    m1 = 64'h1122_3344_5566_7788;
    m2 = 64'h99AA_BBCC_DDEE_FF00;
    done_cnt = 0;
    // Zero-length message: consumed, nothing emitted.
    msg_data = {512{1'b1}}; msg_len = 10'd0; msg_valid = 1'b1; slot_len = 7'd64;
    tick();
    msg_valid = 1'b0;
    tick();
    n_checks++;
    if (msg_ready !== 1'b1 || busy !== 1'b0 || tx_len !== 7'd0 || msg_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len: ready=%b busy=%b len=%0d done=%b, required 1/0/0/0",
               msg_ready, busy, tx_len, msg_done);
    end
    // Two 64-bit messages with msg_valid held high.
    msg_data = {m1, 448'd0}; msg_len = 10'd64; msg_valid = 1'b1;
    tick();
    msg_data = {m2, 448'd0};
    tick();
    if (msg_done === 1'b1) done_cnt++;
    n_checks++;
    if (tx_ipg_data !== m1 || tx_len !== 7'd64 || msg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: data=%h len=%0d done=%b, required data=%h len=64 done=1",
               tx_ipg_data, tx_len, msg_done, m1);
    end
    tick();
    msg_valid = 1'b0;
    if (msg_done === 1'b1) done_cnt++;
    n_checks++;
    if (tx_len !== 7'd0 || tx_ipg_data !== 64'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: len=%0d data=%h busy=%b, required len=0 data=0 busy=1",
               tx_len, tx_ipg_data, busy);
    end
    tick();
    if (msg_done === 1'b1) done_cnt++;
    n_checks++;
    if (tx_ipg_data !== m2 || tx_len !== 7'd64 || msg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: data=%h len=%0d done=%b, required data=%h len=64 done=1",
               tx_ipg_data, tx_len, msg_done, m2);
    end
    tick();
    if (msg_done === 1'b1) done_cnt++;
    n_checks++;
    if (done_cnt != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d pulses, required 2", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_message();
    test_odd_slots();
    test_clamp_short();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
